// File: rtl/kpn_pkg.sv
// Shared KPN definitions: token type and default channel sizing.
package kpn_pkg;
  localparam int KPN_TOKEN_W  = 16;
  localparam int KPN_CH_DEPTH = 8;

  typedef logic [KPN_TOKEN_W-1:0] kpn_token_t;
endpackage

// File: rtl/kpn_channel_mem.sv
// Channel token storage: synchronous write, asynchronous read. Contents are never cleared.
module kpn_channel_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/kpn_fifo_channel.sv
// Bounded FWFT FIFO for one KPN edge; occupancy count disambiguates full/empty, sticky error flags.
module kpn_fifo_channel
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH = KPN_TOKEN_W,
  parameter int DEPTH      = KPN_CH_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic                          full,
  input  logic                          rd,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow,
  output logic                          underflow
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [DATA_WIDTH-1:0] head;
  logic                  wr_ok, rd_ok;

  // A full channel still takes a write when the same edge pops the head.
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd);

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign data_out = empty ? '0 : head;

  kpn_channel_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (data_in),
    .raddr (rptr),
    .rdata (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_ONE;
      if (rd_ok) rptr <= rptr + PTR_ONE;
      if (wr_ok && !rd_ok)      count <= count + CNT_ONE;
      else if (rd_ok && !wr_ok) count <= count - CNT_ONE;
      if (wr && !wr_ok) overflow  <= 1'b1;
      if (rd && !rd_ok) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed bench for kpn_fifo_channel with hand-computed expectations.
module tb_kpn_fifo_channel;
  import kpn_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr, rd;
  kpn_token_t       data_in, data_out;
  logic             full, empty, overflow, underflow;
  logic [3:0]       count;

  int nvec = 0;
  int nmis = 0;

  kpn_fifo_channel #(.DATA_WIDTH(16), .DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .data_in   (data_in),
    .full      (full),
    .rd        (rd),
    .data_out  (data_out),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; data_in = '0;
    #12 reset = 1'b0;
    repeat (3) step();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);

    // Fill 1..8 then drain in order.
    for (int i = 1; i <= 8; i++) begin
      wr = 1'b1; data_in = 16'(i);
      step();
      chk("fill_count", 32'(count), 32'(i));
    end
    wr = 1'b0;
    chk("fill_full", 32'(full), 1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_dout", 32'(data_out), 32'(i));
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    chk("drain_ovf", 32'(overflow), 0);
    chk("drain_unf", 32'(underflow), 0);

    // Overflow on full, then simultaneous push/pop while full.
    for (int i = 0; i < 8; i++) begin
      wr = 1'b1; data_in = 16'h0010 + 16'(i);
      step();
    end
    data_in = 16'h00AA; rd = 1'b0;
    step();
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_head", 32'(data_out), 32'h10);
    data_in = 16'h00BB; rd = 1'b1;
    step();
    wr = 1'b0; rd = 1'b0;
    chk("fullrw_count", 32'(count), 8);
    chk("fullrw_full", 32'(full), 1);
    chk("fullrw_head", 32'(data_out), 32'h11);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", 32'(data_out), (i < 7) ? 32'h11 + 32'(i) : 32'hBB);
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    chk("ovf_drain_empty", 32'(empty), 1);
    chk("ovf_no_unf", 32'(underflow), 0);

    // Read on empty with a simultaneous write.
    wr = 1'b1; rd = 1'b1; data_in = 16'h1234;
    step();
    wr = 1'b0; rd = 1'b0;
    chk("unf_flag", 32'(underflow), 1);
    chk("unf_empty", 32'(empty), 0);
    chk("unf_count", 32'(count), 1);
    chk("unf_dout", 32'(data_out), 32'h1234);
    rd = 1'b1;
    step();
    rd = 1'b0;
    chk("unf_pop_empty", 32'(empty), 1);

    // Streaming at occupancy 3; 23 writes wrap the 8-slot pointers twice.
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; data_in = 16'h0100 + 16'(i);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      chk("stream_dout", 32'(data_out), 32'h100 + 32'(k));
      wr = 1'b1; rd = 1'b1; data_in = 16'h0103 + 16'(k);
      step();
      chk("stream_count", 32'(count), 3);
    end
    wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stream_tail", 32'(data_out), 32'h114 + 32'(i));
      rd = 1'b1;
      step();
    end
    rd = 1'b0;
    chk("stream_empty", 32'(empty), 1);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; data_in = 16'h0200 + 16'(i);
      step();
    end
    wr = 1'b0;
    chk("pre_rst_count", 32'(count), 5);
    #2 reset = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_count", 32'(count), 0);
    chk("arst_dout", 32'(data_out), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_unf", 32'(underflow), 0);
    #2 reset = 1'b0;
    wr = 1'b1; data_in = 16'hBEEF;
    step();
    wr = 1'b0;
    chk("post_rst_dout", 32'(data_out), 32'hBEEF);
    chk("post_rst_count", 32'(count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
